// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more.
module bcd_add3
  import bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] corrected
);

  assign corrected = (digit >= ADD3_THRESH) ? digit + BCD_DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle binary-to-BCD converter (double dabble, one bit per clock).
// Optional leading-zero mask output enabled by defining BCD_LZ_BLANK_EN.
module bcd_seq_converter
  import bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                binary_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out,
  output logic                            busy
`ifdef BCD_LZ_BLANK_EN
  ,
  output logic [DIGITS-1:0]               lz_mask
`endif
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  generate
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
      $error("bcd_seq_converter: DIGITS too small to hold 2**WIDTH-1");
    end
  endgenerate

  state_t             state;
  state_t             state_next;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   acc_corr;
  logic [BCD_W-1:0]   acc_shift;
  logic [WIDTH-1:0]   sreg;
  logic [WIDTH-1:0]   sreg_shift;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit     (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .corrected (acc_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Correct first, then shift the combined {accumulator, source} register.
  assign {acc_shift, sreg_shift} = {acc_corr, sreg} << 1;
  assign last_bit = (cnt == CNT_W'(1));

`ifdef BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] lz_next;
  logic              all_zero;

  always_comb begin
    lz_next  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (acc_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      lz_next[i] = all_zero;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      sreg    <= '0;
      cnt     <= '0;
      bcd_out <= '0;
`ifdef BCD_LZ_BLANK_EN
      lz_mask <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg <= binary_in;
            acc  <= '0;
            cnt  <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          acc  <= acc_shift;
          sreg <= sreg_shift;
          cnt  <= cnt - CNT_W'(1);
          // bcd_out only moves on the edge that enters DONE.
          if (last_bit) begin
            bcd_out <= acc_shift;
`ifdef BCD_LZ_BLANK_EN
            lz_mask <= lz_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed self-checking bench for bcd_seq_converter (default parameters).
// Extra lz_mask checks are compiled in when BCD_LZ_BLANK_EN is defined.
module tb_bcd_seq_converter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  binary_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd_out;
  logic        busy;
`ifdef BCD_LZ_BLANK_EN
  logic [2:0]  lz_mask;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int hs_count = 0;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .binary_in (binary_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .busy      (busy)
`ifdef BCD_LZ_BLANK_EN
    ,
    .lz_mask   (lz_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && out_valid && out_ready) hs_count = hs_count + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] golden(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Present a value in IDLE for one edge, then scramble binary_in.
  task automatic accept(input logic [7:0] v);
    @(negedge clk);
    in_valid  = 1'b1;
    binary_in = v;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    binary_in = 8'hA5;
  endtask

  // Count cycles from the accept edge until out_valid is seen at a negedge.
  task automatic wait_done(output int lat, output bit timeout,
                           output bit busy_drop, output bit ready_seen);
    bit got;
    got = 1'b0; lat = 0; busy_drop = 1'b0; ready_seen = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else begin
        if (!busy) busy_drop = 1'b1;
        if (in_ready) ready_seen = 1'b1;
        lat++;
      end
    end
    timeout = !got;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; binary_in = '0;
    repeat (3) @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (bcd_out !== 12'h000) $display("FAIL rst_bcd got %h want 000", bcd_out); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int lat; bit to, bd, rs;
    accept(8'd0);
    wait_done(lat, to, bd, rs);
    n_total++; if (to || lat != 8) $display("FAIL zero_latency got %0d (timeout %b) want 8", lat, to); else n_pass++;
    n_total++; if (bcd_out !== 12'h000) $display("FAIL zero_bcd got %h want 000", bcd_out); else n_pass++;
`ifdef BCD_LZ_BLANK_EN
    n_total++; if (lz_mask !== 3'b110) $display("FAIL zero_lz got %b want 110", lz_mask); else n_pass++;
`endif
    release_result();
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL zero_idle_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_max();
    int lat; bit to, bd, rs;
    accept(8'd255);
    wait_done(lat, to, bd, rs);
    n_total++; if (to || lat != 8) $display("FAIL max_latency got %0d (timeout %b) want 8", lat, to); else n_pass++;
    n_total++; if (bcd_out !== 12'h255) $display("FAIL max_bcd got %h want 255", bcd_out); else n_pass++;
    n_total++; if (bd || busy !== 1'b1) $display("FAIL max_busy dropped=%b busy_now=%b want busy held", bd, busy); else n_pass++;
    n_total++; if (rs || in_ready !== 1'b0) $display("FAIL max_ready_low seen=%b now=%b want 0", rs, in_ready); else n_pass++;
    release_result();
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL max_ready_after got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL max_valid_after got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL max_busy_after got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_stall();
    int lat; bit to, bd, rs, held;
    accept(8'd45);
    wait_done(lat, to, bd, rs);
    n_total++; if (to || bcd_out !== 12'h045) $display("FAIL stall_bcd got %h want 045", bcd_out); else n_pass++;
`ifdef BCD_LZ_BLANK_EN
    n_total++; if (lz_mask !== 3'b100) $display("FAIL stall_lz got %b want 100", lz_mask); else n_pass++;
`endif
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || bcd_out !== 12'h045 || in_ready !== 1'b0) held = 1'b0;
    end
    n_total++; if (!held) $display("FAIL stall_hold got valid=%b bcd=%h want 1/045", out_valid, bcd_out); else n_pass++;
    release_result();
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL stall_release got ready=%b valid=%b want 1/0", in_ready, out_valid); else n_pass++;
    n_total++; if (bcd_out !== 12'h045) $display("FAIL stall_idle_hold got %h want 045", bcd_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vals [4];
    logic [11:0] exp  [4];
    logic [11:0] res  [4];
    int          t    [4];
    int k; bit to, quiet;
    vals = '{8'd1, 8'd10, 8'd99, 8'd123};
    exp  = '{12'h001, 12'h010, 12'h099, 12'h123};
    to = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b1;
    binary_in = vals[0];
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (!in_ready && k < 40) begin @(negedge clk); k++; end
      if (k >= 40) to = 1'b1;
      @(posedge clk);
      #1 binary_in = 8'd77;
      k = 0;
      do begin @(negedge clk); k++; end while (!out_valid && k < 40);
      if (!out_valid) to = 1'b1;
      res[i] = bcd_out;
      t[i]   = cyc;
      binary_in = (i < 3) ? vals[i+1] : 8'd0;
      if (i == 3) in_valid = 1'b0;
    end
    n_total++; if (to) $display("FAIL b2b_timeout got timeout want progress"); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (res[i] !== exp[i]) $display("FAIL b2b_result%0d got %h want %h", i, res[i], exp[i]); else n_pass++;
    end
    for (int i = 1; i < 4; i++) begin
      n_total++; if (t[i] - t[i-1] != 10) $display("FAIL b2b_spacing%0d got %0d want 10", i, t[i] - t[i-1]); else n_pass++;
    end
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    n_total++; if (!quiet) $display("FAIL b2b_extra got extra result want none"); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; bit to, bd, rs, quiet;
    accept(8'd200);
    repeat (4) @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL rmid_busy got %b want 1", busy); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL rmid_ctrl got busy=%b valid=%b want 0/0", busy, out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (bcd_out !== 12'h000) $display("FAIL rmid_bcd got %h want 000", bcd_out); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_total++; if (!quiet) $display("FAIL rmid_discard got activity want idle"); else n_pass++;
    accept(8'd7);
    wait_done(lat, to, bd, rs);
    n_total++; if (to || lat != 8) $display("FAIL rmid_latency got %0d want 8", lat); else n_pass++;
    n_total++; if (bcd_out !== 12'h007) $display("FAIL rmid_bcd7 got %h want 007", bcd_out); else n_pass++;
    release_result();
  endtask

  task automatic test_exhaustive();
    int lat, base; bit to, bd, rs;
    base = hs_count;
    for (int v = 0; v < 256; v++) begin
      accept(8'(v));
      wait_done(lat, to, bd, rs);
      n_total++;
      if (to || bcd_out !== golden(v))
        $display("FAIL exh_%0d got %h (timeout %b) want %h", v, bcd_out, to, golden(v));
      else n_pass++;
      if (to) break;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result();
    end
    @(negedge clk);
    n_total++; if (hs_count - base != 256) $display("FAIL exh_count got %0d want 256", hs_count - base); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
Multi-cycle binary-to-BCD converter with valid/ready handshakes on input and output. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, so one small datapath replaces the wide combinational converter. It sits between a binary producer (counter, ALU result) and a BCD consumer (7-segment/display driver). Output digit layout matches the existing converter: hundreds in [11:8], tens in [7:4], ones in [3:0] at default parameters.

Parameters:
WIDTH, 8, bit width of binary input.
DIGITS, 3, number of BCD digits in the output. Must satisfy 10^DIGITS > 2^WIDTH-1; elaboration error otherwise.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  binary_in is valid.
in_ready  output  1  converter can accept; high only in IDLE.
binary_in  input  WIDTH  unsigned value to convert.
out_valid  output  1  bcd_out holds a completed result.
out_ready  input  1  consumer accepts result.
bcd_out  output  4*DIGITS  packed BCD; digit i at [4i+3:4i], digit 0 = ones.
busy  output  1  high in SHIFT and DONE.

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous, active-low. While rst_n=0: state=IDLE, bcd_out=0, out_valid=0, busy=0, internal shift register and bit counter cleared.
- States:
  - IDLE: in_ready=1. On in_valid (accept edge E0): latch binary_in into shift register, clear BCD accumulator, bit counter=WIDTH, go to SHIFT.
  - SHIFT: every edge, first add 3 to each accumulator digit >=5, then shift {accumulator, shift_reg} left by 1 and decrement the counter. At the edge where the counter reaches 0 (edge E_WIDTH), load the final accumulator into bcd_out and go to DONE.
  - DONE: out_valid=1. bcd_out is held stable. On out_ready, go to IDLE and drop out_valid on that edge.
- Latency: out_valid is first high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after the accept edge (8 at default).
- Throughput: one conversion per WIDTH+2 cycles. There is no same-cycle accept from DONE: in_ready stays low until IDLE is reached.
- in_valid outside IDLE is ignored, and binary_in changes after acceptance do not affect the result.
- out_ready outside DONE is ignored.
- out_valid held with out_ready=0: the stall is indefinite and bcd_out does not change.
- bcd_out holds its last result through IDLE and SHIFT, and changes only at the edge entering DONE or on reset.
- Counter width is $clog2(WIDTH+1). All arithmetic is unsigned. Digit add-3 is 4-bit and never overflows, because the input to it is always <=9 before the shift.
- Reset mid-SHIFT or mid-DONE: immediate return to IDLE; the partial result is discarded and out_valid goes low without a handshake.

Optional Feature:
Macro BCD_LZ_BLANK_EN.
- Defined: adds output port lz_mask[DIGITS-1:0], registered alongside bcd_out.
  - Bit i=1 when digit i and all higher digits are 0, for i>=1.
  - Bit 0 is always 0, so a lone zero is displayed.
  - Reset value is 0.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package bcd_seq_pkg holds:
  - state enum {IDLE, SHIFT, DONE}
  - localparam BCD_DIGIT_W=4
  - constant ADD3_THRESH=5
- Sub-module bcd_add3: combinational 4-bit digit corrector (d>=5 ? d+3 : d), instantiated DIGITS times via generate.

Test Plan:
1. Reset, then binary_in=0 with in_valid pulse -> out_valid after 8 cycles, bcd_out=12'h000. With BCD_LZ_BLANK_EN, lz_mask=3'b110.
2. binary_in=255 -> bcd_out=12'h255, out_valid exactly 8 cycles after the accept edge; busy high throughout; in_ready low until the cycle after the out_ready handshake.
3. binary_in=45, out_ready held 0 for 20 cycles -> bcd_out stays 12'h045 and out_valid stays 1. Raise out_ready -> IDLE next cycle. lz_mask=3'b100 when enabled.
4. Back-to-back stream 1, 10, 99, 123 with out_ready=1 and in_valid held -> results 12'h001, 12'h010, 12'h099, 12'h123 in order, each WIDTH+2 cycles apart. in_valid pulses while busy (value 77) produce no extra result.
5. Accept 200, assert rst_n=0 at cycle 4 of SHIFT -> outputs cleared immediately. After release, convert 7 -> 12'h007.
6. Exhaustive 0..255 with random out_ready stalls -> every result equals the golden decimal split (hundreds, tens, ones), and no result is dropped or duplicated.
